hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised successor hazard unit for the five-stage RISC-V pipeline, with an added multi-cycle execute unit (MUL/DIV) scoreboard. It generates E-stage forwarding selects, load-use stalls, multi-cycle RAW/WAW/structural stalls, and branch flushes. It tracks one outstanding multi-cycle op with a latency counter and pending-destination register, and sits beside the datapath, driving the F/D/E pipeline-register enables and flushes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- MUL_LAT, 4, multi-cycle unit latency in cycles (>= 1)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D  in  REG_ADDR_W  D-stage source indices
- UsesRs1D, UsesRs2D  in  1  D instruction actually reads Rs1/Rs2
- RdD  in  REG_ADDR_W  D-stage destination
- RegWriteD  in  1  D instruction writes Rd
- MulD  in  1  D instruction is a multi-cycle op
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  E-stage indices
- MemReadE  in  1  E instruction is a load
- MulStartE  in  1  multi-cycle op issuing from E this cycle
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RdW  in  REG_ADDR_W  M/W destinations
- RegWriteM, RegWriteW  in  1  M/W write enables
- StallF, StallD, FlushD, FlushE  out  1  pipeline control
- ForwardAE, ForwardBE  out  2  operand selects
- MulBusy  out  1  multi-cycle op outstanding
- MulDone  out  1  one-cycle writeback strobe for multi-cycle result
- MulRd  out  REG_ADDR_W  destination of outstanding op

## Operation
- Forwarding per operand X in {A,B}: RsXE==0 -> FWD_NONE; else RegWriteM & RdM==RsXE -> FWD_M (01); else RegWriteW & RdW==RsXE -> FWD_W (10); else FWD_NONE. M has priority (youngest producer wins).
- lwStall = MemReadE & RdE!=0 & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)).
- mcStall = MulBusy & ( (UsesRs1D & Rs1D==MulRd) | (UsesRs2D & Rs2D==MulRd) | (RegWriteD & RdD==MulRd) | MulD ). MulRd==0 never causes RAW/WAW (structural still applies).
- stall = lwStall | mcStall. StallF = StallD = stall & ~PCSrcE. FlushD = PCSrcE. FlushE = stall | PCSrcE.
- Tracker states: IDLE (MulBusy=0), BUSY (MulBusy=1). IDLE -> BUSY on MulStartE: load MulRd<=RdE, Cnt<=MUL_LAT-1. BUSY: Cnt decrements; MulDone = BUSY & Cnt==0; BUSY -> IDLE on the edge ending the MulDone cycle.
- MulStartE while BUSY cannot occur (structural stall); if it does, it is ignored.
- PCSrcE never cancels an outstanding op (older than the branch).

## Timing
- Forward/stall/flush outputs combinational from inputs and tracker state; no latency.
- Issue in cycle t: MulBusy=1 in t+1..t+MUL_LAT, MulDone=1 in t+MUL_LAT only, dependent D instruction stalled through t+MUL_LAT, advances at t+MUL_LAT+1. MUL_LAT=1: MulDone in t+1.
- Reset (any time, including mid-op): state IDLE, Cnt=0, MulRd=0, MulBusy=0, MulDone=0; combinational outputs follow with tracker idle. Counters below cleared.
- Simultaneous stall and PCSrcE: flush wins for F/D (no stall), E flushed.

## Configuration
- HAZARD_PERF_EN defined: adds outputs StallCycles, FlushCycles, FwdCycles (32 bits each), incrementing in cycles with stall, PCSrcE, or any non-NONE forward respectively; saturate at all-ones; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- hazard_pkg: fwd_sel_t enum (FWD_NONE=2'b00, FWD_M=2'b01, FWD_W=2'b10), mc_state_t (IDLE, BUSY), default REG_ADDR_W.
- One sub-module: mc_tracker (state, Cnt, MulRd, MulDone), parametrised by MUL_LAT and REG_ADDR_W.

## Test plan
- RdM=5, RdW=5 both writing, Rs1E=5 -> ForwardAE=01; RegWriteM=0 -> 10; Rs1E=0 -> 00.
- Load RdE=7, MemReadE=1, Rs2D=7 UsesRs2D=1 -> StallF=StallD=FlushE=1 one cycle; UsesRs2D=0 -> no stall.
- MUL_LAT=4, MulStartE RdE=9 at t; D reads x9 -> stall t+1..t+4, MulDone only at t+4, proceed at t+5.
- BUSY with MulRd=9; D writes x9 -> WAW stall; D is MulD to x3 -> structural stall; D reads x4 only -> no stall.
- lwStall and PCSrcE same cycle -> StallF=StallD=0, FlushD=FlushE=1; outstanding mul still gives MulDone on schedule.
- rst_n low at t+2 of a MUL_LAT=4 op -> MulBusy=0 immediately, no MulDone; with HAZARD_PERF_EN counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard unit with multi-cycle execute tracking.
package hazard_pkg;

    // Default register-index width for a 32-entry register file.
    localparam int unsigned DEFAULT_REG_ADDR_W = 5;

    // E-stage operand source select; M is the youngest producer.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_W    = 2'b10
    } fwd_sel_t;

    // Multi-cycle unit occupancy.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/mc_tracker.sv
// Scoreboard for the single outstanding multi-cycle (MUL/DIV) operation.
// Latches the destination on issue and counts down the unit latency.
module mc_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [REG_ADDR_W-1:0] o_rd
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    mc_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_rd;

    mc_state_t             w_state_d;
    logic [CNT_W-1:0]      w_cnt_d;
    logic [REG_ADDR_W-1:0] w_rd_d;

    // Next-state: issue only from IDLE; a start while BUSY is ignored.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rd_d    = r_rd;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_d = BUSY;
                    w_cnt_d   = CNT_INIT;
                    w_rd_d    = i_rd;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Tracker state registers; reset abandons any outstanding op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rd    <= w_rd_d;
        end
    end

    assign o_busy = (r_state == BUSY);
    assign o_done = (r_state == BUSY) && (r_cnt == '0);
    assign o_rd   = r_rd;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the five-stage pipeline: E-stage forwarding, load-use stalls,
// multi-cycle RAW/WAW/structural stalls and branch flushes.
// Optional feature macro HAZARD_PERF_EN adds saturating stall/flush/forward counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int unsigned MUL_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic                  UsesRs1D,
    input  logic                  UsesRs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  MulD,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  MemReadE,
    input  logic                  MulStartE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MulBusy,
    output logic                  MulDone,
    output logic [REG_ADDR_W-1:0] MulRd
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           StallCycles,
    output logic [31:0]           FlushCycles,
    output logic [31:0]           FwdCycles
`endif
);

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    logic     w_lw_stall;
    logic     w_mc_stall;
    logic     w_stall;
    logic     w_mc_rd_nz;

    mc_tracker #(
        .MUL_LAT    (MUL_LAT),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mc_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (MulStartE),
        .i_rd    (RdE),
        .o_busy  (MulBusy),
        .o_done  (MulDone),
        .o_rd    (MulRd)
    );

    // Operand forwarding; x0 never forwards and M beats W.
    always_comb begin
        w_fwd_a = FWD_NONE;
        w_fwd_b = FWD_NONE;
        if (Rs1E != '0) begin
            if (RegWriteM && (RdM == Rs1E))      w_fwd_a = FWD_M;
            else if (RegWriteW && (RdW == Rs1E)) w_fwd_a = FWD_W;
        end
        if (Rs2E != '0) begin
            if (RegWriteM && (RdM == Rs2E))      w_fwd_b = FWD_M;
            else if (RegWriteW && (RdW == Rs2E)) w_fwd_b = FWD_W;
        end
    end

    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;

    // Stall sources: load-use, and any D-stage dependency on the busy multi-cycle unit.
    // A pending x0 destination never creates a data hazard, only the structural one.
    always_comb begin
        w_mc_rd_nz = (MulRd != '0);
        w_lw_stall = MemReadE && (RdE != '0) &&
                     ((UsesRs1D && (Rs1D == RdE)) || (UsesRs2D && (Rs2D == RdE)));
        w_mc_stall = MulBusy &&
                     ((w_mc_rd_nz && ((UsesRs1D && (Rs1D == MulRd)) ||
                                      (UsesRs2D && (Rs2D == MulRd)) ||
                                      (RegWriteD && (RdD == MulRd)))) ||
                      MulD);
        w_stall    = w_lw_stall || w_mc_stall;
    end

    // Pipeline control; a taken branch overrides the stall for F/D.
    always_comb begin
        StallF = w_stall && !PCSrcE;
        StallD = w_stall && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = w_stall || PCSrcE;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;
    logic [31:0] r_fwd_cycles;
    logic        w_fwd_any;

    assign w_fwd_any = (w_fwd_a != FWD_NONE) || (w_fwd_b != FWD_NONE);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
            r_fwd_cycles   <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (PCSrcE && (r_flush_cycles != '1))  r_flush_cycles <= r_flush_cycles + 32'd1;
            if (w_fwd_any && (r_fwd_cycles != '1)) r_fwd_cycles   <= r_fwd_cycles + 32'd1;
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCycles = r_flush_cycles;
    assign FwdCycles   = r_fwd_cycles;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios followed by random
// traffic, all compared against a cycle-indexed reference model.
module tb_hazard_unit_mc;

    localparam int RW  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          UsesRs1D, UsesRs2D, RegWriteD, MulD, MemReadE, MulStartE, PCSrcE;
    logic          RegWriteM, RegWriteW;
    logic          StallF, StallD, FlushD, FlushE, MulBusy, MulDone;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [RW-1:0] MulRd;
`ifdef HAZARD_PERF_EN
    logic [31:0]   StallCycles, FlushCycles, FwdCycles;
`endif

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_ADDR_W (RW),
        .MUL_LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .UsesRs1D    (UsesRs1D),
        .UsesRs2D    (UsesRs2D),
        .RdD         (RdD),
        .RegWriteD   (RegWriteD),
        .MulD        (MulD),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .MemReadE    (MemReadE),
        .MulStartE   (MulStartE),
        .PCSrcE      (PCSrcE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MulBusy     (MulBusy),
        .MulDone     (MulDone),
        .MulRd       (MulRd)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles (StallCycles),
        .FlushCycles (FlushCycles),
        .FwdCycles   (FwdCycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the op issued in cycle m_t occupies cycles m_t+1 .. m_t+LAT.
    int            cyc = 0;
    bit            m_active = 0;
    int            m_t = 0;
    logic [RW-1:0] m_rd = '0;
    bit            e_stall, e_fwd;
    int            n_stall = 0, n_flush = 0, n_fwd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_active && (cyc > m_t) && (cyc <= m_t + LAT);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b01;
        if (RegWriteW && RdW == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic check_all(input string tag);
        bit busy, done, lw, mc, stall;
        logic [1:0] fa, fb;
        if (!rst_n) begin
            m_active = 0;
            n_stall  = 0;
            n_flush  = 0;
            n_fwd    = 0;
        end
        busy  = m_busy();
        done  = busy && (cyc == m_t + LAT);
        lw    = MemReadE && RdE != 0 &&
                ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));
        mc    = busy && (MulD || (m_rd != 0 && ((UsesRs1D && Rs1D == m_rd) ||
                                               (UsesRs2D && Rs2D == m_rd) ||
                                               (RegWriteD && RdD == m_rd))));
        stall = lw || mc;
        fa    = ref_fwd(Rs1E);
        fb    = ref_fwd(Rs2E);
        chk({tag, ".StallF"}, 32'(StallF), 32'(stall && !PCSrcE));
        chk({tag, ".StallD"}, 32'(StallD), 32'(stall && !PCSrcE));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(PCSrcE));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(stall || PCSrcE));
        chk({tag, ".FwdA"}, 32'(ForwardAE), 32'(fa));
        chk({tag, ".FwdB"}, 32'(ForwardBE), 32'(fb));
        chk({tag, ".MulBusy"}, 32'(MulBusy), 32'(busy));
        chk({tag, ".MulDone"}, 32'(MulDone), 32'(done));
        if (busy) chk({tag, ".MulRd"}, 32'(MulRd), 32'(m_rd));
`ifdef HAZARD_PERF_EN
        chk({tag, ".StallCycles"}, StallCycles, 32'(n_stall));
        chk({tag, ".FlushCycles"}, FlushCycles, 32'(n_flush));
        chk({tag, ".FwdCycles"}, FwdCycles, 32'(n_fwd));
`endif
        e_stall = stall;
        e_fwd   = (fa != 0) || (fb != 0);
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    // Advance the model across the rising edge, then return to the drive point.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (e_stall) n_stall++;
            if (PCSrcE)  n_flush++;
            if (e_fwd)   n_fwd++;
            if (MulStartE && !m_busy()) begin
                m_active = 1;
                m_t      = cyc;
                m_rd     = RdE;
            end
        end else begin
            m_active = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_in();
        Rs1D = '0; Rs2D = '0; RdD = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        UsesRs1D = 0; UsesRs2D = 0; RegWriteD = 0; MulD = 0; MemReadE = 0;
        MulStartE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        @(posedge clk);
        #1;

        // Reset state.
        settle("reset");
        chk("reset.MulRd", 32'(MulRd), 32'd0);
        chk("reset.MulBusy", 32'(MulBusy), 32'd0);
        tick();
        rst_n = 1'b1;

        // Forwarding priority and x0 exclusion.
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
        settle("fwd_m");
        chk("fwd_m.A", 32'(ForwardAE), 32'd1);
        tick();
        RegWriteM = 0;
        settle("fwd_w");
        chk("fwd_w.A", 32'(ForwardAE), 32'd2);
        tick();
        Rs1E = 0;
        settle("fwd_x0");
        chk("fwd_x0.A", 32'(ForwardAE), 32'd0);
        tick();

        // Load-use stall.
        idle_in();
        MemReadE = 1; RdE = 7; Rs2D = 7; UsesRs2D = 1;
        settle("lw");
        chk("lw.StallD", 32'(StallD), 32'd1);
        chk("lw.FlushE", 32'(FlushE), 32'd1);
        tick();
        UsesRs2D = 0;
        settle("lw_nouse");
        chk("lw_nouse.StallF", 32'(StallF), 32'd0);
        tick();

        // Multi-cycle RAW: dependent instruction held until the result is written.
        idle_in();
        MulStartE = 1; RdE = 9;
        settle("mul_issue");
        tick();
        idle_in();
        UsesRs1D = 1; Rs1D = 9;
        for (int k = 1; k <= LAT; k++) begin
            settle("mul_raw");
            chk("mul_raw.StallD", 32'(StallD), 32'd1);
            chk("mul_raw.MulDone", 32'(MulDone), 32'(k == LAT));
            tick();
        end
        settle("mul_free");
        chk("mul_free.StallD", 32'(StallD), 32'd0);
        chk("mul_free.MulBusy", 32'(MulBusy), 32'd0);
        tick();

        // WAW, structural, independent, then load-use under a taken branch.
        idle_in();
        MulStartE = 1; RdE = 9;
        settle("mul2_issue");
        tick();
        idle_in();
        RegWriteD = 1; RdD = 9;
        settle("waw");
        chk("waw.StallD", 32'(StallD), 32'd1);
        tick();
        RdD = 3; MulD = 1;
        settle("struct");
        chk("struct.StallD", 32'(StallD), 32'd1);
        tick();
        idle_in();
        UsesRs1D = 1; Rs1D = 4;
        settle("indep");
        chk("indep.StallD", 32'(StallD), 32'd0);
        tick();
        idle_in();
        MemReadE = 1; RdE = 7; Rs2D = 7; UsesRs2D = 1; PCSrcE = 1;
        settle("lw_br");
        chk("lw_br.StallF", 32'(StallF), 32'd0);
        chk("lw_br.FlushD", 32'(FlushD), 32'd1);
        chk("lw_br.FlushE", 32'(FlushE), 32'd1);
        chk("lw_br.MulDone", 32'(MulDone), 32'd1);
        tick();
        idle_in();

        // Reset in the middle of an outstanding op.
        MulStartE = 1; RdE = 9;
        settle("rst_issue");
        tick();
        idle_in();
        settle("rst_t1");
        tick();
        rst_n = 1'b0;
        settle("rst_mid");
        chk("rst_mid.MulBusy", 32'(MulBusy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 3; k <= LAT + 1; k++) begin
            settle("rst_after");
            chk("rst_after.MulDone", 32'(MulDone), 32'd0);
            tick();
        end

        // Random traffic over a small register range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            Rs1D      = 5'($urandom_range(0, 7));
            Rs2D      = 5'($urandom_range(0, 7));
            RdD       = 5'($urandom_range(0, 7));
            Rs1E      = 5'($urandom_range(0, 7));
            Rs2E      = 5'($urandom_range(0, 7));
            RdE       = 5'($urandom_range(0, 7));
            RdM       = 5'($urandom_range(0, 7));
            RdW       = 5'($urandom_range(0, 7));
            UsesRs1D  = 1'($urandom_range(0, 1));
            UsesRs2D  = 1'($urandom_range(0, 1));
            RegWriteD = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MulD      = ($urandom_range(0, 3) == 0);
            MemReadE  = ($urandom_range(0, 3) == 0);
            MulStartE = ($urandom_range(0, 4) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            settle("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
